// File: rtl/branch_redirect.sv
// -----------------------------------------------------------------------------
// branch_redirect
// Redirect controller for a static predict-not-taken front end. A resolved
// taken branch/jump in EX captures its target and asks fetch to redirect.
// The controller holds the request until fetch accepts it, then squashes
// the front end for FLUSH_CYCLES more cycles before going idle.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous active-high reset
//   i_ex_valid       EX holds a valid instruction
//   i_ex_is_br       EX instruction is a branch or jump
//   i_ex_taken       branch condition result
//   i_ex_target      resolved target PC
//   i_fetch_ready    fetch accepts the redirect this cycle
//   o_redirect_valid redirect request to fetch
//   o_redirect_pc    PC to load on an accepted redirect
//   o_flush_if       squash IF/ID register
//   o_flush_id       squash ID/EX register
//   o_br_busy        front-end stall
//   o_taken_count    saturating count of accepted taken branches
// -----------------------------------------------------------------------------
module branch_redirect #(
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ex_valid,
    input  logic        i_ex_is_br,
    input  logic        i_ex_taken,
    input  logic [15:0] i_ex_target,
    input  logic        i_fetch_ready,
    output logic        o_redirect_valid,
    output logic [15:0] o_redirect_pc,
    output logic        o_flush_if,
    output logic        o_flush_id,
    output logic        o_br_busy,
    output logic [15:0] o_taken_count
);

    localparam int unsigned CNT_W      = 2;
    localparam int unsigned PC_W       = 16;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);
    localparam logic [PC_W-1:0]  COUNT_MAX  = {PC_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_SQUASH   = 2'd2
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_squash_cnt;
    logic              r_redirect_valid;
    logic [PC_W-1:0]   r_redirect_pc;
    logic              r_flush_if;
    logic              r_flush_id;
    logic              r_br_busy;
    logic [PC_W-1:0]   r_taken_count;

    wire w_taken_event = i_ex_valid & i_ex_is_br & i_ex_taken;

    // State, squash counter and registered outputs all advance together so
    // every output is a flop with no path from the EX/fetch inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_squash_cnt     <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_flush_if       <= 1'b0;
            r_flush_id       <= 1'b0;
            r_br_busy        <= 1'b0;
            r_taken_count    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // fetch_ready is irrelevant here: a request is always
                    // presented for at least one cycle first.
                    if (w_taken_event) begin
                        r_state          <= ST_REDIRECT;
                        r_redirect_pc    <= i_ex_target;
                        r_redirect_valid <= 1'b1;
                        r_flush_if       <= 1'b1;
                        r_flush_id       <= 1'b1;
                        r_br_busy        <= 1'b1;
                        if (r_taken_count != COUNT_MAX) begin
                            r_taken_count <= r_taken_count + PC_W'(1);
                        end
                    end
                end

                ST_REDIRECT: begin
                    if (i_fetch_ready) begin
                        r_state          <= ST_SQUASH;
                        r_squash_cnt     <= FLUSH_LOAD;
                        r_redirect_valid <= 1'b0;
                        r_flush_if       <= 1'b1;
                        r_flush_id       <= 1'b0;
                        r_br_busy        <= 1'b1;
                    end
                end

                ST_SQUASH: begin
                    // Counter value 1 marks the last squash cycle.
                    if (r_squash_cnt == CNT_W'(1)) begin
                        r_state          <= ST_IDLE;
                        r_squash_cnt     <= '0;
                        r_redirect_valid <= 1'b0;
                        r_flush_if       <= 1'b0;
                        r_flush_id       <= 1'b0;
                        r_br_busy        <= 1'b0;
                    end else begin
                        r_squash_cnt <= r_squash_cnt - CNT_W'(1);
                    end
                end

                default: begin
                    r_state          <= ST_IDLE;
                    r_squash_cnt     <= '0;
                    r_redirect_valid <= 1'b0;
                    r_flush_if       <= 1'b0;
                    r_flush_id       <= 1'b0;
                    r_br_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign o_redirect_valid = r_redirect_valid;
    assign o_redirect_pc    = r_redirect_pc;
    assign o_flush_if       = r_flush_if;
    assign o_flush_id       = r_flush_id;
    assign o_br_busy        = r_br_busy;
    assign o_taken_count    = r_taken_count;

endmodule

// File: tb/tb_branch_redirect.sv
// -----------------------------------------------------------------------------
// tb_branch_redirect
// Directed, table-driven bench for branch_redirect (FLUSH_CYCLES=1) plus a
// second instance with FLUSH_CYCLES=3 for the longer squash window.
// -----------------------------------------------------------------------------
module tb_branch_redirect;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_is_br;
    logic        ex_taken;
    logic [15:0] ex_target;
    logic        fetch_ready;

    logic        rv1, fif1, fid1, busy1;
    logic [15:0] pc1, cnt1;
    logic        rv3, fif3, fid3, busy3;
    logic [15:0] pc3, cnt3;

    int n_checks;
    int n_fail;

    branch_redirect #(.FLUSH_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .i_ex_valid(ex_valid), .i_ex_is_br(ex_is_br), .i_ex_taken(ex_taken),
        .i_ex_target(ex_target), .i_fetch_ready(fetch_ready),
        .o_redirect_valid(rv1), .o_redirect_pc(pc1), .o_flush_if(fif1),
        .o_flush_id(fid1), .o_br_busy(busy1), .o_taken_count(cnt1)
    );

    branch_redirect #(.FLUSH_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .i_ex_valid(ex_valid), .i_ex_is_br(ex_is_br), .i_ex_taken(ex_taken),
        .i_ex_target(ex_target), .i_fetch_ready(fetch_ready),
        .o_redirect_valid(rv3), .o_redirect_pc(pc3), .o_flush_if(fif3),
        .o_flush_id(fid3), .o_br_busy(busy3), .o_taken_count(cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v, br, tk;
        logic [15:0] tgt;
        logic        fr;
        logic        e_rv;
        logic [15:0] e_pc;
        logic        e_fif, e_fid, e_busy;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Checks the packed control outputs {rv,fif,fid,busy} and pc/count of dut.
    task automatic chk1(input string name, input logic [3:0] ctl, input logic [15:0] pc,
                        input logic [15:0] cnt);
        chk({name, ".ctl"}, 16'({rv1, fif1, fid1, busy1}), 16'(ctl));
        chk({name, ".pc"},  pc1,  pc);
        chk({name, ".cnt"}, cnt1, cnt);
    endtask

    task automatic drive(input logic v, input logic br, input logic tk,
                         input logic [15:0] tgt, input logic fr);
        ex_valid = v; ex_is_br = br; ex_taken = tk; ex_target = tgt; fetch_ready = fr;
    endtask

    // Apply inputs, take one rising edge, settle just past it.
    task automatic cycle(input logic v, input logic br, input logic tk,
                         input logic [15:0] tgt, input logic fr);
        drive(v, br, tk, tgt, fr);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

        //           v  br tk  tgt      fr  rv pc       fif fid busy cnt
        vecs[0]  = '{1, 1, 0, 16'h0AAA, 1, 0, 16'h0000, 0, 0, 0, 16'd0};
        vecs[1]  = '{1, 0, 1, 16'h0BBB, 1, 0, 16'h0000, 0, 0, 0, 16'd0};
        vecs[2]  = '{0, 1, 1, 16'h0CCC, 1, 0, 16'h0000, 0, 0, 0, 16'd0};
        vecs[3]  = '{1, 1, 1, 16'h0040, 1, 1, 16'h0040, 1, 1, 1, 16'd1};
        vecs[4]  = '{0, 0, 0, 16'h0000, 1, 0, 16'h0040, 1, 0, 1, 16'd1};
        vecs[5]  = '{0, 0, 0, 16'h0000, 1, 0, 16'h0040, 0, 0, 0, 16'd1};
        vecs[6]  = '{1, 1, 1, 16'h1234, 0, 1, 16'h1234, 1, 1, 1, 16'd2};
        vecs[7]  = '{0, 0, 0, 16'h0000, 0, 1, 16'h1234, 1, 1, 1, 16'd2};
        vecs[8]  = '{1, 1, 1, 16'h2000, 0, 1, 16'h1234, 1, 1, 1, 16'd2};
        vecs[9]  = '{0, 0, 0, 16'h0000, 0, 1, 16'h1234, 1, 1, 1, 16'd2};
        vecs[10] = '{0, 0, 0, 16'h0000, 1, 0, 16'h1234, 1, 0, 1, 16'd2};
        vecs[11] = '{1, 1, 1, 16'h3000, 1, 0, 16'h1234, 0, 0, 0, 16'd2};
        vecs[12] = '{1, 1, 1, 16'h0100, 0, 1, 16'h0100, 1, 1, 1, 16'd3};
        vecs[13] = '{1, 1, 1, 16'h2000, 1, 0, 16'h0100, 1, 0, 1, 16'd3};
        vecs[14] = '{0, 0, 0, 16'h0000, 0, 0, 16'h0100, 0, 0, 0, 16'd3};

        // Reset values
        rst = 1'b1;
        #3;
        chk1("reset", 4'b0000, 16'h0000, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven main sequence
        for (int i = 0; i < 15; i++) begin
            cycle(vecs[i].v, vecs[i].br, vecs[i].tk, vecs[i].tgt, vecs[i].fr);
            chk1($sformatf("vec%0d", i),
                 {vecs[i].e_rv, vecs[i].e_fif, vecs[i].e_fid, vecs[i].e_busy},
                 vecs[i].e_pc, vecs[i].e_cnt);
        end

        // Asynchronous reset in the middle of REDIRECT
        cycle(1'b1, 1'b1, 1'b1, 16'h0500, 1'b0);
        chk1("pre_rst_redirect", 4'b1111, 16'h0500, 16'd4);
        #2;
        rst = 1'b1;
        #1;
        chk1("async_rst", 4'b0000, 16'h0000, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // First edge after reset honours a taken event
        cycle(1'b1, 1'b1, 1'b1, 16'h0600, 1'b1);
        chk1("post_rst_first", 4'b1111, 16'h0600, 16'd1);
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        chk1("post_rst_idle", 4'b0000, 16'h0600, 16'd1);

        // Saturation: preload the counter, then three taken branches
        #1;
        force dut.r_taken_count = 16'hFFFD;
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        release dut.r_taken_count;
        #1;
        chk("sat_preload", cnt1, 16'hFFFD);
        cycle(1'b1, 1'b1, 1'b1, 16'h0A00, 1'b1);
        chk("sat_fffe", cnt1, 16'hFFFE);
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 16'h0B00, 1'b1);
        chk("sat_ffff", cnt1, 16'hFFFF);
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 16'h0C00, 1'b1);
        chk("sat_hold", cnt1, 16'hFFFF);
        chk("sat_pc", pc1, 16'h0C00);

        // FLUSH_CYCLES=3: one REDIRECT cycle then three SQUASH cycles
        do_reset();
        cycle(1'b1, 1'b1, 1'b1, 16'h0ABC, 1'b1);
        chk("f3_redirect", 16'({rv3, fif3, fid3, busy3}), 16'(4'b1111));
        chk("f3_pc", pc3, 16'h0ABC);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
            chk($sformatf("f3_squash%0d", k), 16'({rv3, fif3, fid3, busy3}), 16'(4'b0101));
        end
        cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("f3_idle", 16'({rv3, fif3, fid3, busy3}), 16'(4'b0000));
        chk("f3_cnt", cnt3, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
